// File: rtl/util_io_loop_seq.sv
// Sweep controller for the util_io_loop self-test datapath: steps the loop through
// STEP_NUM baud settings, runs one stream per step and tallies compare errors.
module util_io_loop_seq #(
    parameter int unsigned STEP_NUM      = 8,
    parameter int unsigned TIMEOUT_W     = 24,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [11:0]          cfg_freq_base,
    input  logic [11:0]          cfg_freq_step,
    input  logic [15:0]          cfg_limit,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    output logic                 loop_enable,
    output logic [11:0]          loop_baud_freq,
    output logic [15:0]          loop_baud_limit,
    output logic                 loop_stream_start,
    input  logic                 loop_stream_busy,
    input  logic                 loop_cmp_error,
    input  logic                 loop_cmp_error_valid,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           step_idx,
    output logic [31:0]          err_total,
    output logic [STEP_NUM-1:0]  fail_mask,
    output logic                 timeout_flag
);

    localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam int unsigned SW          = (SETTLE_LAST > 0) ? $clog2(SETTLE_LAST + 1) : 1;
    localparam logic [7:0]  LAST_STEP   = 8'(STEP_NUM - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG,
        S_SETTLE,
        S_START,
        S_WAIT_BUSY,
        S_RUN,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [SW-1:0]         scnt;
    logic [TIMEOUT_W-1:0]  tcnt;
    logic [11:0]           freq_q;
    logic [15:0]           limit_q;
    logic [11:0]           freq_cfg;
    logic [STEP_NUM-1:0]   step_bit;
    logic                  settle_end;
    logic                  tmo_hit;
    logic                  timeout_evt;
    logic                  step_inc;
    logic                  sweep_clr;
    logic                  err_evt;

    assign settle_end = (scnt == SW'(SETTLE_LAST));
    assign tmo_hit    = (cfg_timeout != '0) && (tcnt == cfg_timeout - TIMEOUT_W'(1));
    assign freq_cfg   = cfg_freq_base + ({4'b0000, step_idx} * cfg_freq_step);
    assign step_bit   = STEP_NUM'(1) << step_idx;
    assign sweep_clr  = (state == S_IDLE) && start;
    assign err_evt    = ((state == S_RUN) || (state == S_DRAIN)) &&
                        loop_cmp_error_valid && loop_cmp_error;

    always_comb begin
        state_nxt   = state;
        timeout_evt = 1'b0;
        step_inc    = 1'b0;
        case (state)
            S_IDLE:      if (start) state_nxt = S_CFG;
            S_CFG:       state_nxt = S_SETTLE;
            S_SETTLE:    if (settle_end) state_nxt = S_START;
            S_START:     state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (loop_stream_busy) begin
                    state_nxt = S_RUN;
                end else if (tmo_hit) begin
                    state_nxt   = S_NEXT;
                    timeout_evt = 1'b1;
                end
            end
            S_RUN: begin
                if (!loop_stream_busy) begin
                    state_nxt = S_DRAIN;
                end else if (tmo_hit) begin
                    state_nxt   = S_NEXT;
                    timeout_evt = 1'b1;
                end
            end
            S_DRAIN:     if (settle_end) state_nxt = S_NEXT;
            S_NEXT: begin
                if (step_idx == LAST_STEP) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_CFG;
                    step_inc  = 1'b1;
                end
            end
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
        // abort overrides every transition and suppresses its side effects
        if (abort && (state != S_IDLE)) begin
            state_nxt   = S_IDLE;
            timeout_evt = 1'b0;
            step_inc    = 1'b0;
        end
    end

    always_comb begin
        loop_enable       = 1'b0;
        loop_stream_start = 1'b0;
        case (state)
            S_SETTLE, S_RUN, S_DRAIN: loop_enable = 1'b1;
            S_START, S_WAIT_BUSY: begin
                loop_enable       = 1'b1;
                loop_stream_start = 1'b1;
            end
            default: ;
        endcase
        busy = (state != S_IDLE);
        done = (state == S_DONE);
        // CFG presents the freshly computed setting; later states hold what CFG sampled
        loop_baud_freq  = (state == S_CFG) ? freq_cfg  : freq_q;
        loop_baud_limit = (state == S_CFG) ? cfg_limit : limit_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            scnt  <= '0;
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                scnt <= '0;
                tcnt <= '0;
            end else begin
                if ((state == S_SETTLE) || (state == S_DRAIN)) scnt <= scnt + SW'(1);
                if ((state == S_WAIT_BUSY) || (state == S_RUN)) tcnt <= tcnt + TIMEOUT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            freq_q  <= '0;
            limit_q <= '0;
        end else if (state == S_CFG) begin
            freq_q  <= freq_cfg;
            limit_q <= cfg_limit;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            step_idx     <= '0;
            err_total    <= '0;
            fail_mask    <= '0;
            timeout_flag <= 1'b0;
        end else if (sweep_clr) begin
            step_idx     <= '0;
            err_total    <= '0;
            fail_mask    <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (step_inc) step_idx <= step_idx + 8'd1;
            if (timeout_evt) timeout_flag <= 1'b1;
            if (timeout_evt || err_evt) fail_mask <= fail_mask | step_bit;
            if (err_evt && (err_total != '1)) err_total <= err_total + 32'd1;
        end
    end

endmodule
